apb_cfg_master: RTL and testbench

//  APB requester (master) for the configuration memory and other APB completers on pclk.

---
 rtl/apb_cfg_master.sv | 143 ++++++++++++++
 tb/tb_apb_cfg_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - APB requester with valid/ready command and response channels
//
// Purpose:
//   Takes single read/write commands from the system side and runs one APB
//   SETUP/ACCESS transfer per command. It honours pready wait states and
//   pslverr, and aborts a stalled ACCESS phase after TIMEOUT cycles. The
//   result is held on a valid/ready response channel until it is consumed.
//
// Ports:
//   i_pclk, i_prstn                       clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready             command handshake
//   i_cmd_write, i_cmd_addr, i_cmd_wdata  command fields
//   o_rsp_valid / i_rsp_ready             response handshake
//   o_rsp_rdata, o_rsp_err, o_rsp_timeout response fields
//   o_psel, o_penable, o_pwrite,
//   o_paddr, o_pwdata                     APB request signals
//   i_prdata, i_pready, i_pslverr         APB completer signals
module apb_cfg_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_pclk,
  input  logic              i_prstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  // A TIMEOUT of 0 would give a zero-width counter; keep one bit in that case.
  localparam int CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int LAST_I  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_timeout;
  logic              w_timeout_hit;

  // Abort on the last allowed low-pready cycle so ACCESS never exceeds TIMEOUT cycles.
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_cmd_valid) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (i_pready || w_timeout_hit) w_next = S_RESP;
      S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_paddr  <= i_cmd_addr;
            r_pwdata <= i_cmd_wdata;
            r_pwrite <= i_cmd_write;
          end
        end
        S_SETUP: begin
          r_cnt <= '0;
        end
        S_ACCESS: begin
          if (i_pready) begin
            // Completion wins over a timeout landing on the same cycle.
            r_rdata   <= (!r_pwrite && !i_pslverr) ? i_prdata : '0;
            r_err     <= i_pslverr;
            r_timeout <= 1'b0;
          end else begin
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
            if (w_timeout_hit) begin
              r_rdata   <= '0;
              r_err     <= 1'b1;
              r_timeout <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // APB strobes are decoded from state so an async reset drops them at once.
  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign o_penable     = (r_state == S_ACCESS);
  assign o_rsp_valid   = (r_state == S_RESP);
  assign o_pwrite      = r_pwrite;
  assign o_paddr       = r_paddr;
  assign o_pwdata      = r_pwdata;
  assign o_rsp_rdata   = r_rdata;
  assign o_rsp_err     = r_err;
  assign o_rsp_timeout = r_timeout;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - self-checking bench for apb_cfg_master
module tb_apb_cfg_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  apb_cfg_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(16)) dut (
    .i_pclk(clk), .i_prstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_rsp_timeout(rsp_timeout),
    .o_psel(psel), .o_penable(penable), .o_pwrite(pwrite),
    .o_paddr(paddr), .o_pwdata(pwdata),
    .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;     // pready-low ACCESS cycles before pready=1
    logic        slverr;
    logic [31:0] prdata;
    int          bp;        // rsp_ready-low cycles once the response is up
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_acc;   // expected ACCESS cycles
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    rsp_t e, got;
    logic [31:0] h_rdata;
    logic        h_err, h_to;
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    pready    = 1'b0;
    pslverr   = 1'b1;   // must be ignored while pready is low
    prdata    = 32'hBAD0BAD0;
    tick();             // accepted at this edge -> SETUP
    cmd_valid = 1'b0;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    sb.push_back(e);
    chk("setup_psel", {30'd0, psel, penable}, 32'd2);
    chk("setup_paddr", {16'd0, paddr}, {16'd0, v.addr});
    chk("setup_pwrite", {31'd0, pwrite}, {31'd0, v.write});
    chk("setup_pwdata", pwdata, v.wdata);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (!(psel && penable)) break;
      cyc++;
      if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.write)
        chk("access_stable", {16'd0, paddr}, {16'd0, v.addr});
      if (cyc > v.waits) begin
        pready = 1'b1; pslverr = v.slverr; prdata = v.prdata;
      end else begin
        pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0BAD0;
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    chk("access_cycles", cyc, v.exp_acc);
    chk("resp_valid", {29'd0, rsp_valid, psel, penable}, 32'd4);
    h_rdata = rsp_rdata; h_err = rsp_err; h_to = rsp_timeout;
    for (int b = 0; b < v.bp; b++) begin
      cmd_valid = 1'b1;   // must have no effect while in RESP
      tick();
      chk("bp_hold", {26'd0, rsp_valid, cmd_ready, psel, penable, rsp_err, rsp_timeout},
          {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, h_err, h_to});
      chk("bp_rdata", rsp_rdata, h_rdata);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, got.rdata);
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, got.err});
      chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, got.to});
    end
    tick();
    rsp_ready = 1'b0;
    chk("idle_after", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    chk("paddr_retained", {16'd0, paddr}, {16'd0, v.addr});
  endtask

  initial begin
    // write, rdata ignored for writes
    vecs[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 0,   1'b0, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0, 1};
    // read with 3 waits
    vecs[1] = '{1'b0, 16'h0004, 32'h0,        3,   1'b0, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0, 4};
    // slave error on read
    vecs[2] = '{1'b0, 16'h0008, 32'h0,        0,   1'b1, 32'hAAAA5555, 2, 32'h0,        1'b1, 1'b0, 1};
    // pready stuck low -> timeout after 16 ACCESS cycles
    vecs[3] = '{1'b0, 16'h0020, 32'h0,        100, 1'b0, 32'h11111111, 0, 32'h0,        1'b1, 1'b1, 16};
    // write with error after waits, long backpressure
    vecs[4] = '{1'b1, 16'h0030, 32'h0BADF00D, 2,   1'b1, 32'h22222222, 5, 32'h0,        1'b1, 1'b0, 3};
    // pready rises on the very last allowed cycle: completion beats timeout
    vecs[5] = '{1'b0, 16'hFFFC, 32'h0,        15,  1'b0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0, 1'b0, 16};
    vecs[6] = '{1'b0, 16'h1234, 32'h0,        14,  1'b0, 32'h5A5A5A5A, 0, 32'h5A5A5A5A, 1'b0, 1'b0, 15};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) tick();
    chk("rst_apb", {29'd0, psel, penable, pwrite}, 32'd0);
    chk("rst_paddr", {16'd0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Async reset in the middle of a stalled ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0040; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_access", {30'd0, psel, penable}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_apb", {29'd0, psel, penable, rsp_valid}, 32'd0);
    tick();
    #2;
    rstn = 1'b1;
    tick();
    chk("post_rst_ready", {29'd0, cmd_ready, rsp_valid, psel}, 32'd4);
    repeat (3) tick();
    chk("no_rsp_after_rst", {30'd0, rsp_valid, psel}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
